// File: rtl/axi_input_fifo_pkg.sv
// Shared definitions for the AXI input FIFO: write FSM encoding, default depth,
// and the block-length table selected by sel.
package axi_input_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_ERR  = 2'd2
  } wr_state_t;

  localparam int DEPTH_DEFAULT = 16;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  blk_len_t;

  // Block length in 32-bit words, indexed by sel.
  localparam blk_len_t BLK_LEN [4] = '{5'd7, 5'd8, 5'd12, 5'd16};

  function automatic blk_len_t blk_len(input logic [1:0] sel);
    return BLK_LEN[sel];
  endfunction

endpackage

// File: rtl/axi_input_fifo_if.sv
// AXI write-data channel (W beats) between an upstream master and the FIFO.
interface axi_input_fifo_if;
  import axi_input_fifo_pkg::*;

  word_t s_wdata;
  logic  s_wvalid;
  logic  s_wlast;
  logic  s_wready;

  modport master (output s_wdata, s_wvalid, s_wlast, input s_wready);
  modport slave  (input s_wdata, s_wvalid, s_wlast, output s_wready);

endinterface

// File: rtl/axi_input_fifo.sv
// AXI input FIFO: accepts 32-bit write beats grouped into fixed-length blocks,
// checks burst length against sel, and presents the stored data one byte at a
// time (little-endian byte order) with a marker on the final byte of each block.
module axi_input_fifo
  import axi_input_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            wclk,
  input  logic            ARESETn,
  axi_input_fifo_if.slave s,
  input  logic [1:0]      sel,
  input  logic            clear,
  input  logic            rd_en,
  output logic [7:0]      data_out,
  output logic            out_valid,
  output logic            last_byte,
  output logic            err_wlast
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

  word_t       mem [DEPTH];
  logic [AW:0] wptr_reg, rptr_reg;
  logic [1:0]  bidx_reg;
  logic [3:0]  rcnt_reg;
  blk_len_t    lq0_reg, lq1_reg;
  logic [1:0]  lq_cnt_reg;

  wr_state_t   state_reg, state_next;
  logic [3:0]  beat_cnt_reg, beat_cnt_next;
  blk_len_t    len_reg, len_next;
  logic        err_reg, err_next;
  logic        ready_en_reg;

  logic        full, empty, ready, wr_en, blk_start;
  logic        rd_fire, word_done, blk_done;
  word_t       rd_word;
  blk_len_t    start_len;

  assign full      = (wptr_reg ^ rptr_reg) == PTR_WRAP;
  assign empty     = (wptr_reg == rptr_reg);
  assign start_len = blk_len(sel);

  assign s.s_wready = ready;
  assign err_wlast  = err_reg;

  assign out_valid = !empty;
  assign rd_word   = mem[rptr_reg[AW-1:0]];
  assign data_out  = rd_word[{bidx_reg, 3'b000} +: 8];
  assign last_byte = out_valid && (bidx_reg == 2'd3) && ({1'b0, rcnt_reg} == lq0_reg - 5'd1);

  assign rd_fire   = rd_en && out_valid;
  assign word_done = rd_fire && (bidx_reg == 2'd3);
  assign blk_done  = rd_fire && last_byte;

  // Write FSM next state: beat acceptance, burst-length check, sticky error.
  // A new block is held off while two blocks are already tracked by the
  // length queue, since the queue has only two entries.
  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    len_next      = len_reg;
    err_next      = err_reg;
    ready         = 1'b0;
    wr_en         = 1'b0;
    blk_start     = 1'b0;

    case (state_reg)
      ST_IDLE: ready = ready_en_reg && !full && (lq_cnt_reg != 2'd2);
      ST_RECV: ready = ready_en_reg && !full;
      default: ready = 1'b0;
    endcase

    wr_en = s.s_wvalid && ready && !clear;

    if (wr_en) begin
      if (state_reg == ST_IDLE) begin
        blk_start     = 1'b1;
        len_next      = start_len;
        beat_cnt_next = 4'd1;
        if (s.s_wlast) begin
          state_next = ST_ERR;
          err_next   = 1'b1;
        end else begin
          state_next = ST_RECV;
        end
      end else begin
        beat_cnt_next = beat_cnt_reg + 4'd1;
        if ({1'b0, beat_cnt_reg} == len_reg - 5'd1) begin
          if (s.s_wlast) begin
            state_next    = ST_IDLE;
            beat_cnt_next = 4'd0;
          end else begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end
        end else if (s.s_wlast) begin
          state_next = ST_ERR;
          err_next   = 1'b1;
        end
      end
    end

    if (clear) begin
      state_next    = ST_IDLE;
      beat_cnt_next = 4'd0;
      err_next      = 1'b0;
    end
  end

  // Write FSM state register; ready stays low until the first edge after reset.
  always_ff @(posedge wclk or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= 4'd0;
      len_reg      <= '0;
      err_reg      <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      len_reg      <= len_next;
      err_reg      <= err_next;
      ready_en_reg <= 1'b1;
    end
  end

  // Storage array write port; contents survive reset and clear.
  always_ff @(posedge wclk) begin
    if (wr_en) mem[wptr_reg[AW-1:0]] <= s.s_wdata;
  end

  // FIFO pointers, byte index within the head word, and word count within the block.
  always_ff @(posedge wclk or negedge ARESETn) begin
    if (!ARESETn) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      bidx_reg <= 2'd0;
      rcnt_reg <= 4'd0;
    end else if (clear) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      bidx_reg <= 2'd0;
      rcnt_reg <= 4'd0;
    end else begin
      if (wr_en)     wptr_reg <= wptr_reg + PTR_ONE;
      if (word_done) rptr_reg <= rptr_reg + PTR_ONE;
      if (rd_fire)   bidx_reg <= bidx_reg + 2'd1;
      if (blk_done)       rcnt_reg <= 4'd0;
      else if (word_done) rcnt_reg <= rcnt_reg + 4'd1;
    end
  end

  // Length queue: pushed when a block starts, popped when its last byte is consumed.
  always_ff @(posedge wclk or negedge ARESETn) begin
    if (!ARESETn) begin
      lq0_reg    <= '0;
      lq1_reg    <= '0;
      lq_cnt_reg <= 2'd0;
    end else if (clear) begin
      lq0_reg    <= '0;
      lq1_reg    <= '0;
      lq_cnt_reg <= 2'd0;
    end else begin
      case ({blk_start, blk_done})
        2'b10: begin
          if (lq_cnt_reg == 2'd0) lq0_reg <= start_len;
          else                    lq1_reg <= start_len;
          lq_cnt_reg <= lq_cnt_reg + 2'd1;
        end
        2'b01: begin
          lq0_reg    <= lq1_reg;
          lq_cnt_reg <= lq_cnt_reg - 2'd1;
        end
        2'b11: begin
          if (lq_cnt_reg == 2'd1) begin
            lq0_reg <= start_len;
          end else begin
            lq0_reg <= lq1_reg;
            lq1_reg <= start_len;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_input_fifo.sv
// Self-checking bench for axi_input_fifo: directed scenarios plus random bursts,
// compared every cycle against a queue-based reference model.
module tb_axi_input_fifo;
  import axi_input_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       wclk = 1'b0;
  logic       ARESETn = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       clear = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       out_valid;
  logic       last_byte;
  logic       err_wlast;

  axi_input_fifo_if bus ();

  axi_input_fifo #(.DEPTH(DEPTH)) dut (
    .wclk      (wclk),
    .ARESETn   (ARESETn),
    .s         (bus),
    .sel       (sel),
    .clear     (clear),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .out_valid (out_valid),
    .last_byte (last_byte),
    .err_wlast (err_wlast)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored words in order, each tagged with "final word of its block".
  word_t wq[$];
  bit    wl[$];
  int    m_bidx, m_beat, m_len, blocks_open;
  bit    m_inburst, m_err;

  int rd_count, dut_last_n, dut_last_pos;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", tag, $time);
  endtask

  function automatic int len_of(input logic [1:0] sl);
    case (sl)
      2'd0:    return 7;
      2'd1:    return 8;
      2'd2:    return 12;
      default: return 16;
    endcase
  endfunction

  function automatic bit rd_pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(1));
  endfunction

  function automatic void model_clear();
    wq.delete();
    wl.delete();
    m_bidx = 0;
    m_beat = 0;
    m_len = 0;
    blocks_open = 0;
    m_inburst = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void model_step(input bit acc, input word_t d, input bit lst,
                                     input logic [1:0] sl, input bit clr, input bit rd);
    bit fin;
    if (clr) begin
      model_clear();
    end else begin
      if (rd) begin
        if (m_bidx == 3) begin
          if (wl[0]) blocks_open--;
          void'(wq.pop_front());
          void'(wl.pop_front());
          m_bidx = 0;
        end else begin
          m_bidx++;
        end
      end
      if (acc) begin
        if (!m_inburst) begin
          m_len = len_of(sl);
          m_beat = 0;
          blocks_open++;
        end
        fin = (m_beat == m_len - 1);
        wq.push_back(d);
        wl.push_back(fin);
        m_beat++;
        if (lst != fin) begin
          m_err = 1'b1;
          m_inburst = 1'b0;
        end else begin
          m_inburst = !fin;
        end
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.s_wvalid = 1'b0;
    bus.s_wdata  = '0;
    bus.s_wlast  = 1'b0;
    clear        = 1'b0;
    rd_en        = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input bit vld, input word_t d, input bit lst, input logic [1:0] sl,
                       input bit clr, input bit rd, output bit acc);
    bit         exp_ready, exp_valid, exp_last;
    logic [7:0] exp_byte;
    word_t      head;
    bus.s_wvalid = vld;
    bus.s_wdata  = d;
    bus.s_wlast  = lst;
    sel          = sl;
    clear        = clr;
    rd_en        = rd;
    exp_ready = !m_err && (wq.size() < DEPTH) && !(!m_inburst && blocks_open >= 2);
    exp_valid = (wq.size() != 0);
    exp_last  = 1'b0;
    exp_byte  = '0;
    if (exp_valid) begin
      head     = wq[0];
      exp_byte = head[8*m_bidx +: 8];
      exp_last = (m_bidx == 3) && wl[0];
    end
    #3;
    check("s_wready", bus.s_wready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    check("err_wlast", err_wlast, m_err);
    if (exp_valid) begin
      check("data_out", data_out, exp_byte);
      check("last_byte", last_byte, exp_last);
    end else begin
      check("last_byte_idle", last_byte, 0);
    end
    if (rd && exp_valid) begin
      rd_count++;
      if (last_byte === 1'b1) begin
        dut_last_n++;
        dut_last_pos = rd_count;
      end
    end
    @(posedge wclk);
    acc = vld && exp_ready && !clr;
    model_step(acc, d, lst, sl, clr, rd && exp_valid);
    #1;
  endtask

  task automatic send_burst(input logic [1:0] sl, input int nbeats, input int last_at,
                            input int rd_mode, input int gap_pct, input bit pattern,
                            output int ncyc);
    int accepted;
    accepted = 0;
    ncyc = 0;
    for (int b = 0; b < nbeats && !m_err; b++) begin
      word_t d;
      bit    acc;
      int    guard;
      if (pattern) d = {8'(4*b+4), 8'(4*b+3), 8'(4*b+2), 8'(4*b+1)};
      else         d = $urandom;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 1000) begin
        cycle(($urandom_range(99) >= gap_pct), d, (b + 1 == last_at), sl, 1'b0,
              rd_pick(rd_mode), acc);
        guard++;
        ncyc++;
      end
      if (!acc) begin
        timeout_fail("beat_accept");
        break;
      end
      accepted++;
    end
    $display("burst sel=%0d beats=%0d accepted=%0d cycles=%0d err_wlast=%0b",
             sl, nbeats, accepted, ncyc, m_err);
  endtask

  task automatic drain(input int rd_mode);
    int guard;
    bit acc;
    guard = 0;
    while (wq.size() != 0 && guard < 2000) begin
      cycle(1'b0, '0, 1'b0, sel, 1'b0, rd_pick(rd_mode), acc);
      guard++;
    end
    if (wq.size() != 0) timeout_fail("drain");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int ncyc;
    int g;
    idle_inputs();
    model_clear();

    // Reset state
    #12;
    check("rst_s_wready", bus.s_wready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_last_byte", last_byte, 0);
    check("rst_err_wlast", err_wlast, 0);
    #10 ARESETn = 1'b1;
    @(posedge wclk);
    @(posedge wclk);
    #1;

    // sel=0, 7 patterned beats: bytes 01..1C, last_byte only on byte 28
    rd_count = 0; dut_last_n = 0; dut_last_pos = 0;
    send_burst(2'd0, 7, 7, 2, 0, 1'b1, ncyc);
    drain(1);
    check("blk7_last_pos", dut_last_pos, 28);
    check("blk7_last_count", dut_last_n, 1);

    // sel=3, 16 beats without reading: FIFO full, next beat held until a word frees
    send_burst(2'd3, 16, 16, 0, 0, 1'b0, ncyc);
    repeat (3) cycle(1'b1, 32'hA5A5_0001, 1'b0, 2'd0, 1'b0, 1'b0, acc);
    acc = 1'b0;
    g = 0;
    while (!acc && g < 20) begin
      cycle(1'b1, 32'hA5A5_0001, 1'b0, 2'd0, 1'b0, 1'b1, acc);
      g++;
    end
    if (!acc) timeout_fail("beat17_accept");
    send_burst(2'd0, 6, 6, 2, 0, 1'b0, ncyc);
    drain(1);

    // sel=1, wlast on beat 5: error sticks until clear
    send_burst(2'd1, 5, 5, 0, 0, 1'b0, ncyc);
    cycle(1'b1, 32'h1234_5678, 1'b0, 2'd1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 2'd1, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 2'd1, 1'b0, 1'b0, acc);

    // sel=2, 12 beats with continuous reads: no stall, last_byte at byte 48
    rd_count = 0; dut_last_n = 0; dut_last_pos = 0;
    send_burst(2'd2, 12, 12, 1, 0, 1'b0, ncyc);
    check("blk12_cycles", ncyc, 12);
    drain(1);
    check("blk12_last_pos", dut_last_pos, 48);
    check("blk12_last_count", dut_last_n, 1);

    // Asynchronous reset mid-burst, then a fresh sel=0 burst
    send_burst(2'd0, 3, 0, 0, 0, 1'b0, ncyc);
    idle_inputs();
    #2 ARESETn = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_s_wready", bus.s_wready, 0);
    check("arst_last_byte", last_byte, 0);
    check("arst_err_wlast", err_wlast, 0);
    model_clear();
    @(posedge wclk);
    #2 ARESETn = 1'b1;
    @(posedge wclk);
    @(posedge wclk);
    #1;
    rd_count = 0; dut_last_n = 0; dut_last_pos = 0;
    send_burst(2'd0, 7, 7, 2, 0, 1'b1, ncyc);
    drain(1);
    check("post_rst_last_pos", dut_last_pos, 28);

    // Random bursts with gaps and random reads; occasional malformed bursts then clear
    for (int i = 0; i < 30; i++) begin
      logic [1:0] sl;
      int         len, k;
      sl  = 2'($urandom_range(3));
      len = len_of(sl);
      if ($urandom_range(7) == 0) begin
        if ($urandom_range(1) == 1) begin
          k = $urandom_range(len - 1, 1);
          send_burst(sl, k, k, 2, 25, 1'b0, ncyc);
        end else begin
          send_burst(sl, len, 0, 2, 25, 1'b0, ncyc);
        end
        cycle(1'b0, '0, 1'b0, sl, 1'b0, 1'b0, acc);
        cycle(1'b0, '0, 1'b0, sl, 1'b1, 1'b0, acc);
      end else begin
        send_burst(sl, len, len, 2, 25, 1'b0, ncyc);
      end
    end
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
